// File: rtl/alu8.sv
// alu8: 8-bit registered ALU with a 4-bit opcode, carry in and carry out.
// Interface contract: there is no handshake. Operands, carry_in and opcode are
// sampled on every rising clk edge, and the matching sum/carry_out is presented
// right after that edge and held until the next one. A new operation can be
// issued every cycle. rst is synchronous, active-high, and overrides opcode.
module alu8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       carry_in,
    input  logic [3:0] opcode,
    output logic [7:0] sum,
    output logic       carry_out
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADC  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_SBB  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_NOT  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_RCL  = 4'd11,
        OP_RCR  = 4'd12,
        OP_INC  = 4'd13,
        OP_DEC  = 4'd14,
        OP_PASS = 4'd15
    } op_e;

    op_e op;
    assign op = op_e'(opcode);

    // Widened intermediates: bit 8 of each 9-bit result is the carry or borrow.
    // Subtraction wraps modulo 512, so bit 8 is set exactly when the true
    // difference is negative.
    logic [8:0]  add_w;
    logic [8:0]  adc_w;
    logic [8:0]  sub_w;
    logic [8:0]  sbb_w;
    logic [15:0] mul_w;

    assign add_w = {1'b0, in_a} + {1'b0, in_b};
    assign adc_w = add_w + {8'b0, carry_in};
    assign sub_w = {1'b0, in_a} - {1'b0, in_b};
    assign sbb_w = sub_w - {8'b0, carry_in};
    assign mul_w = {8'b0, in_a} * {8'b0, in_b};

    logic [7:0] sum_d;
    logic [7:0] sum_q;
    logic       carry_d;
    logic       carry_q;

    // Select the result and flag for the current opcode.
    always_comb begin
        sum_d   = 8'h00;
        carry_d = 1'b0;
        case (op)
            OP_ADD: begin
                sum_d   = add_w[7:0];
                carry_d = add_w[8];
            end
            OP_ADC: begin
                sum_d   = adc_w[7:0];
                carry_d = adc_w[8];
            end
            OP_SUB: begin
                sum_d   = sub_w[7:0];
                carry_d = sub_w[8];
            end
            OP_MUL: begin
                sum_d   = mul_w[7:0];
                carry_d = |mul_w[15:8];
            end
            OP_SBB: begin
                sum_d   = sbb_w[7:0];
                carry_d = sbb_w[8];
            end
            OP_AND:  sum_d = in_a & in_b;
            OP_OR:   sum_d = in_a | in_b;
            OP_XOR:  sum_d = in_a ^ in_b;
            OP_NOT:  sum_d = ~in_a;
            OP_SHL: begin
                sum_d   = {in_a[6:0], 1'b0};
                carry_d = in_a[7];
            end
            OP_SHR: begin
                sum_d   = {1'b0, in_a[7:1]};
                carry_d = in_a[0];
            end
            OP_RCL: begin
                sum_d   = {in_a[6:0], carry_in};
                carry_d = in_a[7];
            end
            OP_RCR: begin
                sum_d   = {carry_in, in_a[7:1]};
                carry_d = in_a[0];
            end
            OP_INC: begin
                sum_d   = in_a + 8'd1;
                carry_d = (in_a == 8'hFF);
            end
            OP_DEC: begin
                sum_d   = in_a - 8'd1;
                carry_d = (in_a == 8'h00);
            end
            OP_PASS: sum_d = in_b;
        endcase
    end

    // Output registers; reset clears them and wins over any opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_alu8.sv
// tb_alu8: directed and swept stimulus for alu8, checked against an
// arithmetic model of the opcode table through an expected-value queue.
module tb_alu8;

    localparam int W = 30; // {op[4], a[8], b[8], cin, carry, sum[8]}

    logic       clk;
    logic       rst;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       carry_in;
    logic [3:0] opcode;
    logic [7:0] sum;
    logic       carry_out;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    int           n_checks;
    int           n_errors;

    alu8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .carry_in  (carry_in),
        .opcode    (opcode),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // Plain integer arithmetic on the opcode table; returns {carry, result}.
    function automatic logic [8:0] model(input int a, input int b, input int cin, input int op);
        int         r;
        bit         c;
        logic [7:0] av;
        logic [7:0] bv;
        av = 8'(a);
        bv = 8'(b);
        r  = 0;
        c  = 1'b0;
        case (op)
            0:  begin r = a + b;        c = (r > 255); end
            1:  begin r = a + b + cin;  c = (r > 255); end
            2:  begin r = a - b + 256;  c = (a < b); end
            3:  begin r = a * b;        c = (r > 255); end
            4:  begin r = a - b - cin + 512; c = (a < b + cin); end
            5:  r = int'(av & bv);
            6:  r = int'(av | bv);
            7:  r = int'(av ^ bv);
            8:  r = 255 - a;
            9:  begin r = a * 2;             c = (a >= 128); end
            10: begin r = a / 2;             c = (a % 2 == 1); end
            11: begin r = a * 2 + cin;       c = (a >= 128); end
            12: begin r = a / 2 + 128 * cin; c = (a % 2 == 1); end
            13: begin r = a + 1;             c = (a == 255); end
            14: begin r = a + 255;           c = (a == 0); end
            default: r = b;
        endcase
        r = r % 256;
        return {c, r[7:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [3:0] op);
        logic [8:0] x;
        @(negedge clk);
        rst      = r;
        in_a     = a;
        in_b     = b;
        carry_in = c;
        opcode   = op;
        x = r ? 9'h000 : model(int'(a), int'(b), int'(c), int'(op));
        exp_q.push_back({op, a, b, c, x});
    endtask

    // Directed vector: pins the model to a hand-computed value, then drives it.
    task automatic vec(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [3:0] op, input logic [7:0] es, input logic ec);
        logic [8:0] m;
        m = model(int'(a), int'(b), int'(c), int'(op));
        n_checks++;
        if (m !== {ec, es}) begin
            n_errors++;
            $display("FAIL model op=%0d a=%h b=%h cin=%b: got sum=%h c=%b, need sum=%h c=%b",
                     op, a, b, c, m[7:0], m[8], es, ec);
        end
        drive(1'b0, a, b, c, op);
    endtask

    // ---------------- scoreboard compare ----------------
    // Checks the registered outputs just after each edge that consumed a vector.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({carry_out, sum} !== e[8:0]) begin
                n_errors++;
                $display("FAIL dut op=%0d a=%h b=%h cin=%b: got sum=%h c=%b, need sum=%h c=%b",
                         e[29:26], e[25:18], e[17:10], e[9], sum, carry_out, e[7:0], e[8]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        in_a     = 8'h00;
        in_b     = 8'h00;
        carry_in = 1'b0;
        opcode   = 4'd0;

        // Reset with MUL operands present, then release.
        drive(1'b1, 8'd5, 8'd10, 1'b0, 4'd3);
        vec(8'd5,   8'd10,  1'b0, 4'd3,  8'd50,  1'b0);

        // MUL
        vec(8'd20,  8'd20,  1'b0, 4'd3,  8'd144, 1'b1);
        vec(8'd255, 8'd255, 1'b0, 4'd3,  8'h01,  1'b1);
        vec(8'd16,  8'd16,  1'b0, 4'd3,  8'h00,  1'b1);

        // ADD / ADC / SUB / SBB
        vec(8'd200, 8'd100, 1'b0, 4'd0,  8'd44,  1'b1);
        vec(8'd255, 8'd1,   1'b0, 4'd0,  8'd0,   1'b1);
        vec(8'd10,  8'd20,  1'b1, 4'd1,  8'd31,  1'b0);
        vec(8'd10,  8'd20,  1'b0, 4'd2,  8'd246, 1'b1);
        vec(8'd0,   8'd1,   1'b0, 4'd2,  8'd255, 1'b1);
        vec(8'd20,  8'd10,  1'b1, 4'd4,  8'd9,   1'b0);
        vec(8'd10,  8'd10,  1'b1, 4'd4,  8'd255, 1'b1);

        // Logic
        vec(8'hF0,  8'h3C,  1'b1, 4'd5,  8'h30,  1'b0);
        vec(8'hF0,  8'h3C,  1'b1, 4'd6,  8'hFC,  1'b0);
        vec(8'hF0,  8'h3C,  1'b1, 4'd7,  8'hCC,  1'b0);
        vec(8'hF0,  8'h3C,  1'b1, 4'd8,  8'h0F,  1'b0);
        vec(8'hF0,  8'h3C,  1'b1, 4'd15, 8'h3C,  1'b0);

        // Shift / rotate
        vec(8'h81,  8'h00,  1'b1, 4'd9,  8'h02,  1'b1);
        vec(8'h81,  8'h00,  1'b1, 4'd10, 8'h40,  1'b1);
        vec(8'h81,  8'h00,  1'b0, 4'd11, 8'h02,  1'b1);
        vec(8'h81,  8'h00,  1'b0, 4'd12, 8'h40,  1'b1);
        vec(8'h81,  8'h00,  1'b1, 4'd11, 8'h03,  1'b1);
        vec(8'h81,  8'h00,  1'b1, 4'd12, 8'hC0,  1'b1);
        vec(8'h40,  8'h00,  1'b0, 4'd11, 8'h80,  1'b0);

        // INC / DEC
        vec(8'hFF,  8'h55,  1'b1, 4'd13, 8'h00,  1'b1);
        vec(8'h00,  8'h55,  1'b1, 4'd14, 8'hFF,  1'b1);
        vec(8'h07,  8'h55,  1'b1, 4'd13, 8'h08,  1'b0);
        vec(8'h07,  8'h55,  1'b0, 4'd14, 8'h06,  1'b0);

        // Back-to-back with a mid-stream reset.
        vec(8'd3,   8'd4,   1'b0, 4'd3,  8'd12,  1'b0);
        drive(1'b1, 8'd200, 8'd100, 1'b0, 4'd0);
        vec(8'd200, 8'd100, 1'b0, 4'd0,  8'd44,  1'b1);

        // Sweep every opcode with varied operands and carry_in.
        for (int i = 0; i < 192; i++) begin
            drive((i == 97), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 4'(i % 16));
        end
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd15);

        // Let the scoreboard drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d entries left, need 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
